// File: rtl/if_pc_unit_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings (also used by the
// D-stage control decoder) and the instruction-memory address window.
package if_pc_unit_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT_DEF  = 32'h0000_6FFC;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Branch offset: sign-extended word offset converted to a byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

  // True when the address cannot be fetched: misaligned or outside the IM window.
  function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] limit);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr > limit);
  endfunction

endpackage

// File: rtl/if_pc_unit_npc_calc.sv
// Next-PC target generation and redirect priority; purely combinational.
module if_pc_unit_npc_calc
  import if_pc_unit_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input  logic [31:0] f_pc_i,
  input  logic        en_i,
  input  logic [31:0] d_pc_i,
  input  logic [1:0]  d_npc_sel_i,
  input  logic        d_br_taken_i,
  input  logic [15:0] d_imm16_i,
  input  logic [25:0] d_imm26_i,
  input  logic [31:0] d_rs_i,
  input  logic        d_eret_i,
  input  logic [31:0] epc_i,
  input  logic        exc_req_i,
  output logic [31:0] npc_o
);

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;
  npc_sel_e    sel;

  // Targets are relative to the branch in D, so the delay slot in F still retires.
  assign seq_pc    = f_pc_i + 32'd4;
  assign br_target = d_pc_i + 32'd4 + br_offset(d_imm16_i);
  assign j_target  = {d_pc_i[31:28], d_imm26_i, 2'b00};
  assign sel       = npc_sel_e'(d_npc_sel_i);

  // Exceptions and eret redirect even when the hazard unit is stalling fetch.
  always_comb begin
    npc_o = seq_pc;
    if (exc_req_i) begin
      npc_o = EXC_ENTRY;
    end else if (d_eret_i) begin
      npc_o = epc_i;
    end else if (!en_i) begin
      npc_o = f_pc_i;
    end else begin
      unique case (sel)
        NPC_BR:  npc_o = d_br_taken_i ? br_target : seq_pc;
        NPC_J:   npc_o = j_target;
        NPC_JR:  npc_o = d_rs_i;
        default: npc_o = seq_pc;
      endcase
    end
  end

endmodule

// File: rtl/if_pc_unit.sv
// Instruction-fetch stage: fetch PC register, IM address drive and
// qualification of the fetched word ahead of the F/D pipeline register.
module if_pc_unit
  import if_pc_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE   = IM_BASE_DEF,
  parameter logic [31:0] IM_LIMIT  = IM_LIMIT_DEF,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic [31:0] D_PC,
  input  logic [1:0]  D_npc_sel,
  input  logic        D_br_taken,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        exc_req,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_exc_adel
);

  logic [31:0] f_pc_q;
  logic [31:0] f_pc_d;

  if_pc_unit_npc_calc #(
    .EXC_ENTRY(EXC_ENTRY)
  ) u_npc_calc (
    .f_pc_i      (f_pc_q),
    .en_i        (En),
    .d_pc_i      (D_PC),
    .d_npc_sel_i (D_npc_sel),
    .d_br_taken_i(D_br_taken),
    .d_imm16_i   (D_imm16),
    .d_imm26_i   (D_imm26),
    .d_rs_i      (D_rs),
    .d_eret_i    (D_eret),
    .epc_i       (EPC),
    .exc_req_i   (exc_req),
    .npc_o       (f_pc_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc_q <= PC_RESET;
    end else begin
      f_pc_q <= f_pc_d;
    end
  end

  assign F_PC        = f_pc_q;
  assign i_inst_addr = f_pc_q;
  assign F_exc_adel  = fetch_addr_bad(f_pc_q, IM_BASE, IM_LIMIT);

  // eret has no delay slot, so whatever sits in F behind it is squashed.
  assign F_instr = (F_exc_adel || D_eret) ? INSTR_NOP : i_inst_rdata;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed plus randomized check of if_pc_unit against a next-PC model
// derived from the fetch rules; the IM is a combinational address hash.
module tb_if_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        En;
  logic [31:0] D_PC;
  logic [1:0]  D_npc_sel;
  logic        D_br_taken;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] D_rs;
  logic        D_eret;
  logic [31:0] EPC;
  logic        exc_req;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_instr;
  logic        F_exc_adel;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign i_inst_rdata = im_word(i_inst_addr);

  if_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .En          (En),
    .D_PC        (D_PC),
    .D_npc_sel   (D_npc_sel),
    .D_br_taken  (D_br_taken),
    .D_imm16     (D_imm16),
    .D_imm26     (D_imm26),
    .D_rs        (D_rs),
    .D_eret      (D_eret),
    .EPC         (EPC),
    .exc_req     (exc_req),
    .i_inst_addr (i_inst_addr),
    .i_inst_rdata(i_inst_rdata),
    .F_PC        (F_PC),
    .F_instr     (F_instr),
    .F_exc_adel  (F_exc_adel)
  );

  function automatic bit m_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] off;
    off = {{16{D_imm16[15]}}, D_imm16} * 32'd4;
    if (exc_req)  return 32'h4180;
    if (D_eret)   return EPC;
    if (!En)      return m_pc;
    if (D_npc_sel == 2'd1 && D_br_taken) return D_PC + 32'd4 + off;
    if (D_npc_sel == 2'd2) return (D_PC & 32'hF000_0000) | ({6'd0, D_imm26} * 32'd4);
    if (D_npc_sel == 2'd3) return D_rs;
    return m_pc + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_instr;
    #1;
    exp_instr = (m_adel(m_pc) || D_eret) ? 32'h0 : im_word(m_pc);
    chk({tag, ".pc"}, F_PC, m_pc);
    chk({tag, ".addr"}, i_inst_addr, m_pc);
    chk({tag, ".adel"}, {31'd0, F_exc_adel}, {31'd0, m_adel(m_pc)});
    chk({tag, ".instr"}, F_instr, exp_instr);
    $display("txn %-10s pc=%h adel=%0b instr=%h", tag, F_PC, F_exc_adel, F_instr);
  endtask

  // Check the current F state, then advance one edge and the model with it.
  task automatic cycle(input string tag);
    logic [31:0] nxt;
    check_outputs(tag);
    nxt = m_next();
    @(posedge clk);
    m_pc = nxt;
    @(negedge clk);
  endtask

  task automatic idle();
    En = 1'b1; D_npc_sel = 2'd0; D_br_taken = 1'b0;
    exc_req = 1'b0; D_eret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; D_PC = 32'h0; D_imm16 = 16'h0; D_imm26 = 26'h0;
    D_rs = 32'h0; EPC = 32'h0; idle();
    m_pc = 32'h3000;
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle("seq");

    D_PC = 32'h3008; D_npc_sel = 2'd1; D_br_taken = 1'b1; D_imm16 = 16'hFFFE;
    cycle("br_taken");
    chk("br_target", m_pc, 32'h3004);
    D_br_taken = 1'b0;
    cycle("br_not");
    idle(); cycle("after_br");

    D_PC = 32'h3010; D_npc_sel = 2'd2; D_imm26 = 26'h0000C40;
    cycle("jump");
    D_npc_sel = 2'd3; D_rs = 32'h3200; cycle("jr");
    D_rs = 32'h3202; cycle("jr_mis");
    idle(); cycle("mis_fetch");
    D_npc_sel = 2'd3; D_rs = 32'h3100; cycle("jr_back");

    En = 1'b0; D_npc_sel = 2'd2; D_imm26 = 26'h0001000;
    for (int i = 0; i < 4; i++) cycle("stall");
    exc_req = 1'b1; cycle("stall_exc");
    idle(); cycle("handler");

    exc_req = 1'b1; D_eret = 1'b1; EPC = 32'h3040; cycle("exc_eret");
    exc_req = 1'b0; cycle("eret");
    idle(); cycle("after_eret");

    D_npc_sel = 2'd3; D_rs = 32'h2FFC; cycle("jr_lo");
    idle(); D_npc_sel = 2'd3; D_rs = 32'h3000; cycle("below");
    D_rs = 32'h6FFC; cycle("base");
    D_rs = 32'h7000; cycle("limit");
    idle(); cycle("above");

    En = 1'b0; D_npc_sel = 2'd2; cycle("pre_rst");
    #1 reset = 1'b0;
    m_pc = 32'h3000;
    check_outputs("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_outputs("rst_hold");
    reset = 1'b1; idle();
    cycle("rst_rel");

    for (int i = 0; i < 400; i++) begin
      En         = ($urandom_range(0, 3) != 0);
      exc_req    = ($urandom_range(0, 19) == 0);
      D_eret     = ($urandom_range(0, 14) == 0);
      D_npc_sel  = 2'($urandom_range(0, 3));
      D_br_taken = 1'($urandom);
      D_PC       = m_pc - 32'd4;
      D_imm16    = 16'($urandom);
      D_imm26    = 26'($urandom);
      D_rs       = ($urandom_range(0, 7) == 0) ? $urandom
                   : ($urandom_range(32'h3000, 32'h6FFC) & 32'hFFFF_FFFC);
      EPC        = $urandom_range(32'h3000, 32'h6FFC) & 32'hFFFF_FFFC;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
